data_memory_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port data_memory between requester 0 (CPU load/store stage) and requester 1 (DMA/video reader). It owns the memory's address, write_enable and data_in, and grants one owner at a time. A burst limit bounds starvation. Read data is registered back to the granted requester one cycle after the access.

---
 rtl/data_memory_pkg.sv | 25 ++
 rtl/data_memory_arbiter_if.sv | 31 +++
 rtl/data_memory_arbiter_fsm.sv | 115 +++++++++++
 rtl/data_memory_arbiter.sv | 88 ++++++++
 tb/tb_data_memory_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_pkg
// Shared types and default sizes for the data_memory arbiter slice.
//   arb_state_t : ownership state of the single-port memory
//   D_DEF/W_DEF : default address / word width of data_memory
//   burst_w()   : width of the burst counter for a given burst limit
// ---------------------------------------------------------------------------
package data_memory_pkg;

    localparam int D_DEF         = 6;
    localparam int W_DEF         = 32;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // One extra bit over the index width keeps MAX_BURST=1 at a legal width.
    function automatic int burst_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_memory_arbiter_if
// One requester's connection to the data_memory arbiter.
//   req/we/addr/wdata : access request driven by the requester
//   gnt               : requester owns the memory this cycle
//   rsp_valid         : one-cycle pulse, rsp_data holds this requester's read
//   rsp_data          : registered read data (shared by both requesters)
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface data_memory_arbiter_if #(
    parameter int D = 6,
    parameter int W = 32
);
    logic         req;
    logic         we;
    logic [D-1:0] addr;
    logic [W-1:0] wdata;
    logic         gnt;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rsp_valid, rsp_data
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rsp_valid, rsp_data
    );
endinterface

// File: rtl/data_memory_arbiter_fsm.sv
// ---------------------------------------------------------------------------
// rr_arbiter_fsm
// Round-robin ownership FSM with a burst limit.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   req0_i, req1_i : access requests
//   gnt0_o, gnt1_o : registered grants (one-hot or zero)
//   sel_o          : registered datapath select, 1 = requester 1 owns
// ---------------------------------------------------------------------------
module rr_arbiter_fsm
    import data_memory_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic sel_o
);

    localparam int             BW         = burst_w(MAX_BURST);
    localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_t    state_q, state_d;
    logic          last_served_q, last_served_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          gnt0_q, gnt1_q, sel_q;
    logic          access_s;

    // Next ownership, burst count and round-robin pointer.
    always_comb begin
        state_d       = state_q;
        burst_d       = burst_q;
        last_served_d = last_served_q;
        access_s      = ((state_q == OWN0) && req0_i) || ((state_q == OWN1) && req1_i);

        case (state_q)
            IDLE: begin
                if (req0_i && req1_i) begin
                    state_d = last_served_q ? OWN0 : OWN1;
                end else if (req0_i) begin
                    state_d = OWN0;
                end else if (req1_i) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0: begin
                if (!req0_i) begin
                    state_d = req1_i ? OWN1 : IDLE;
                end else if ((burst_q == BURST_LAST) && req1_i) begin
                    state_d = OWN1;
                end else begin
                    state_d = OWN0;
                end
            end
            OWN1: begin
                if (!req1_i) begin
                    state_d = req0_i ? OWN0 : IDLE;
                end else if ((burst_q == BURST_LAST) && req0_i) begin
                    state_d = OWN0;
                end else begin
                    state_d = OWN1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any change of owner restarts the burst; an unopposed owner saturates.
        if (state_d != state_q) begin
            burst_d = '0;
        end else if (access_s && (burst_q != BURST_LAST)) begin
            burst_d = burst_q + BW'(1);
        end else begin
            burst_d = burst_q;
        end

        if (state_d == OWN0) begin
            last_served_d = 1'b0;
        end else if (state_d == OWN1) begin
            last_served_d = 1'b1;
        end else begin
            last_served_d = last_served_q;
        end
    end

    // State register; grants are registered from the next state so they never glitch.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            burst_q       <= '0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            sel_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            burst_q       <= burst_d;
            gnt0_q        <= (state_d == OWN0);
            gnt1_q        <= (state_d == OWN1);
            sel_q         <= (state_d == OWN1);
        end
    end

    assign gnt0_o = gnt0_q;
    assign gnt1_o = gnt1_q;
    assign sel_o  = sel_q;

endmodule

// File: rtl/data_memory_arbiter.sv
// ---------------------------------------------------------------------------
// data_memory_arbiter
// Shares the single-port data_memory between requester 0 (CPU) and
// requester 1 (DMA/video) with round-robin ownership and a burst limit.
//   clk_i, rst_n_i       : clock, synchronous active-low reset
//   req0_if, req1_if     : requester interfaces (slave side)
//   mem_write_enable_o   : to data_memory write_enable
//   mem_address_o        : to data_memory address
//   mem_data_in_o        : to data_memory data_in
//   mem_data_out_i       : from data_memory data_out (combinational read)
// ---------------------------------------------------------------------------
module data_memory_arbiter
    import data_memory_pkg::*;
#(
    parameter int D         = D_DEF,
    parameter int W         = W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    data_memory_arbiter_if.slave  req0_if,
    data_memory_arbiter_if.slave  req1_if,
    output logic                  mem_write_enable_o,
    output logic [D-1:0]          mem_address_o,
    output logic [W-1:0]          mem_data_in_o,
    input  logic [W-1:0]          mem_data_out_i
);

    logic         gnt0_s, gnt1_s, sel_s;
    logic         acc0_s, acc1_s;
    logic         rd0_s, rd1_s;
    logic         rsp_valid0_q, rsp_valid1_q;
    logic [W-1:0] rsp_data_q;

    rr_arbiter_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req0_i  (req0_if.req),
        .req1_i  (req1_if.req),
        .gnt0_o  (gnt0_s),
        .gnt1_o  (gnt1_s),
        .sel_o   (sel_s)
    );

    // Access qualification and the memory-side mux (requester 0 when idle).
    always_comb begin
        acc0_s = gnt0_s && req0_if.req;
        acc1_s = gnt1_s && req1_if.req;
        rd0_s  = acc0_s && !req0_if.we;
        rd1_s  = acc1_s && !req1_if.we;
        if (sel_s) begin
            mem_address_o      = req1_if.addr;
            mem_data_in_o      = req1_if.wdata;
            mem_write_enable_o = rst_n_i && acc1_s && req1_if.we;
        end else begin
            mem_address_o      = req0_if.addr;
            mem_data_in_o      = req0_if.wdata;
            mem_write_enable_o = rst_n_i && acc0_s && req0_if.we;
        end
    end

    // Read response register: one-cycle valid pulse, data held until next read.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            rsp_valid0_q <= rd0_s;
            rsp_valid1_q <= rd1_s;
            if (rd0_s || rd1_s) begin
                rsp_data_q <= mem_data_out_i;
            end else begin
                rsp_data_q <= rsp_data_q;
            end
        end
    end

    assign req0_if.gnt       = gnt0_s;
    assign req1_if.gnt       = gnt1_s;
    assign req0_if.rsp_valid = rsp_valid0_q;
    assign req1_if.rsp_valid = rsp_valid1_q;
    assign req0_if.rsp_data  = rsp_data_q;
    assign req1_if.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_memory_arbiter
// Directed bench for data_memory_arbiter with a behavioural data_memory
// (falling-edge write, combinational read). Inputs change 1 time unit after
// the rising edge; outputs are compared 2 units after the rising edge.
// ---------------------------------------------------------------------------
module tb_data_memory_arbiter;

    localparam int D = 6;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         mem_we;
    logic [D-1:0] mem_addr;
    logic [W-1:0] mem_din;
    logic [W-1:0] mem_dout;
    logic [W-1:0] mem_q [0:63];

    int chk_cnt;
    int pass_cnt;

    data_memory_arbiter_if #(.D(D), .W(W)) rq0_if ();
    data_memory_arbiter_if #(.D(D), .W(W)) rq1_if ();

    data_memory_arbiter #(.D(D), .W(W), .MAX_BURST(4)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .req0_if            (rq0_if),
        .req1_if            (rq1_if),
        .mem_write_enable_o (mem_we),
        .mem_address_o      (mem_addr),
        .mem_data_in_o      (mem_din),
        .mem_data_out_i     (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port data_memory.
    always @(negedge clk) begin
        if (mem_we) mem_q[mem_addr] <= mem_din;
    end
    assign mem_dout = mem_q[mem_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [D-1:0] addr, input logic [W-1:0] wdata);
        rq0_if.req = req; rq0_if.we = we; rq0_if.addr = addr; rq0_if.wdata = wdata;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [D-1:0] addr, input logic [W-1:0] wdata);
        rq1_if.req = req; rq1_if.we = we; rq1_if.addr = addr; rq1_if.wdata = wdata;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive0(1'b0, 1'b0, 6'd0, 32'd0);
        drive1(1'b0, 1'b0, 6'd0, 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        for (int i = 0; i < 64; i++) mem_q[i] = 32'd0;
        rst_n = 1'b0;
        drive0(1'b0, 1'b0, 6'd0, 32'd0);
        drive1(1'b0, 1'b0, 6'd0, 32'd0);

        // ---------------- Reset state ----------------
        do_reset();
        #1;
        check_eq("rst_gnt0", {31'd0, rq0_if.gnt}, 32'd0);
        check_eq("rst_gnt1", {31'd0, rq1_if.gnt}, 32'd0);
        check_eq("rst_rspv0", {31'd0, rq0_if.rsp_valid}, 32'd0);
        check_eq("rst_rspv1", {31'd0, rq1_if.rsp_valid}, 32'd0);
        check_eq("rst_rspdata", rq0_if.rsp_data, 32'd0);

        // ---------------- 1: write then read by requester 0 ----------------
        next_cycle();                                   // cycle 0
        drive0(1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
        #1;
        check_eq("t1_c0_gnt0", {31'd0, rq0_if.gnt}, 32'd0);
        check_eq("t1_c0_we", {31'd0, mem_we}, 32'd0);
        next_cycle();                                   // cycle 1: write
        #1;
        check_eq("t1_c1_gnt0", {31'd0, rq0_if.gnt}, 32'd1);
        check_eq("t1_c1_we", {31'd0, mem_we}, 32'd1);
        check_eq("t1_c1_addr", {26'd0, mem_addr}, 32'd5);
        check_eq("t1_c1_din", mem_din, 32'hDEADBEEF);
        next_cycle();                                   // cycle 2: read
        drive0(1'b1, 1'b0, 6'd5, 32'd0);
        #1;
        check_eq("t1_c2_we", {31'd0, mem_we}, 32'd0);
        check_eq("t1_c2_rspv0", {31'd0, rq0_if.rsp_valid}, 32'd0);
        next_cycle();                                   // cycle 3: response
        drive0(1'b0, 1'b0, 6'd0, 32'd0);
        #1;
        check_eq("t1_c3_rspv0", {31'd0, rq0_if.rsp_valid}, 32'd1);
        check_eq("t1_c3_rspdata", rq0_if.rsp_data, 32'hDEADBEEF);
        check_eq("t1_c3_gnt0", {31'd0, rq0_if.gnt}, 32'd1);
        next_cycle();                                   // cycle 4
        #1;
        check_eq("t1_c4_rspv0", {31'd0, rq0_if.rsp_valid}, 32'd0);
        check_eq("t1_c4_gnt0", {31'd0, rq0_if.gnt}, 32'd0);
        check_eq("t1_c4_hold", rq0_if.rsp_data, 32'hDEADBEEF);

        // ---------------- 2: both requesting, burst alternation ----------------
        do_reset();
        drive0(1'b1, 1'b0, 6'd1, 32'd0);
        drive1(1'b1, 1'b0, 6'd2, 32'd0);
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            #1;
            check_eq($sformatf("t2_gnt0_%0d", i), {31'd0, rq0_if.gnt}, ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("t2_gnt1_%0d", i), {31'd0, rq1_if.gnt}, ((i / 4) % 2 == 0) ? 32'd0 : 32'd1);
        end
        drive0(1'b0, 1'b0, 6'd0, 32'd0);
        drive1(1'b0, 1'b0, 6'd0, 32'd0);
        #1;
        check_eq("t2_drop_gnt0", {31'd0, rq0_if.gnt}, 32'd1);
        check_eq("t2_drop_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        #1;
        check_eq("t2_idle_gnt0", {31'd0, rq0_if.gnt}, 32'd0);
        check_eq("t2_idle_gnt1", {31'd0, rq1_if.gnt}, 32'd0);

        // ---------------- 3: requester 1 reads two words ----------------
        mem_q[10] = 32'h11;
        mem_q[11] = 32'h22;
        next_cycle();                                   // cycle 0
        drive1(1'b1, 1'b0, 6'd10, 32'd0);
        next_cycle();                                   // cycle 1: read 10
        #1;
        check_eq("t3_c1_gnt1", {31'd0, rq1_if.gnt}, 32'd1);
        next_cycle();                                   // cycle 2: read 11
        drive1(1'b1, 1'b0, 6'd11, 32'd0);
        #1;
        check_eq("t3_c2_rspv1", {31'd0, rq1_if.rsp_valid}, 32'd1);
        check_eq("t3_c2_rspdata", rq1_if.rsp_data, 32'h11);
        check_eq("t3_c2_rspv0", {31'd0, rq0_if.rsp_valid}, 32'd0);
        next_cycle();                                   // cycle 3
        drive1(1'b0, 1'b0, 6'd0, 32'd0);
        #1;
        check_eq("t3_c3_rspv1", {31'd0, rq1_if.rsp_valid}, 32'd1);
        check_eq("t3_c3_rspdata", rq1_if.rsp_data, 32'h22);
        check_eq("t3_c3_rspv0", {31'd0, rq0_if.rsp_valid}, 32'd0);
        next_cycle();                                   // cycle 4
        #1;
        check_eq("t3_c4_rspv1", {31'd0, rq1_if.rsp_valid}, 32'd0);
        check_eq("t3_c4_hold", rq1_if.rsp_data, 32'h22);
        next_cycle();                                   // IDLE

        // ---------------- 4: owner drops, direct handover, fresh burst ----------------
        drive0(1'b1, 1'b0, 6'd0, 32'd0);                // cycle 0
        next_cycle();                                   // cycle 1: OWN0, access
        drive1(1'b1, 1'b0, 6'd3, 32'd0);
        #1;
        check_eq("t4_c1_gnt0", {31'd0, rq0_if.gnt}, 32'd1);
        next_cycle();                                   // cycle 2: req0 released
        drive0(1'b0, 1'b0, 6'd0, 32'd0);
        #1;
        check_eq("t4_c2_gnt0", {31'd0, rq0_if.gnt}, 32'd1);
        check_eq("t4_c2_we", {31'd0, mem_we}, 32'd0);
        next_cycle();                                   // cycle 3: OWN1 without gap
        drive0(1'b1, 1'b0, 6'd0, 32'd0);
        #1;
        check_eq("t4_c3_gnt1", {31'd0, rq1_if.gnt}, 32'd1);
        check_eq("t4_c3_gnt0", {31'd0, rq0_if.gnt}, 32'd0);
        for (int i = 0; i < 3; i++) begin           // full burst proves burst_cnt restarted at 0
            next_cycle();
            #1;
            check_eq($sformatf("t4_burst_gnt1_%0d", i), {31'd0, rq1_if.gnt}, 32'd1);
        end
        next_cycle();                                   // cycle 7: forced handover
        #1;
        check_eq("t4_c7_gnt0", {31'd0, rq0_if.gnt}, 32'd1);
        drive0(1'b0, 1'b0, 6'd0, 32'd0);
        drive1(1'b0, 1'b0, 6'd0, 32'd0);
        next_cycle();
        next_cycle();
        #1;
        check_eq("t4_idle_gnt0", {31'd0, rq0_if.gnt}, 32'd0);

        // ---------------- 5: reset during a write access ----------------
        mem_q[20] = 32'hAAAA5555;
        drive0(1'b1, 1'b0, 6'd20, 32'd0);               // cycle 0
        next_cycle();                                   // cycle 1: read 20
        #1;
        check_eq("t5_c1_gnt0", {31'd0, rq0_if.gnt}, 32'd1);
        next_cycle();                                   // cycle 2: write under reset
        drive0(1'b1, 1'b1, 6'd20, 32'h12345678);
        rst_n = 1'b0;
        #1;
        check_eq("t5_c2_rspv0", {31'd0, rq0_if.rsp_valid}, 32'd1);
        check_eq("t5_c2_rspdata", rq0_if.rsp_data, 32'hAAAA5555);
        check_eq("t5_c2_we", {31'd0, mem_we}, 32'd0);
        next_cycle();                                   // cycle 3: after reset
        rst_n = 1'b1;
        drive0(1'b0, 1'b0, 6'd0, 32'd0);
        #1;
        check_eq("t5_c3_gnt0", {31'd0, rq0_if.gnt}, 32'd0);
        check_eq("t5_c3_gnt1", {31'd0, rq1_if.gnt}, 32'd0);
        check_eq("t5_c3_rspv0", {31'd0, rq0_if.rsp_valid}, 32'd0);
        check_eq("t5_c3_rspdata", rq0_if.rsp_data, 32'd0);
        check_eq("t5_mem20", mem_q[20], 32'hAAAA5555);

        // ---------------- 6: two writers to addr 63, then read back ----------------
        next_cycle();                                   // cycle 0 (last_served=1 -> 0 first)
        drive0(1'b1, 1'b1, 6'd63, 32'h0BADF00D);
        drive1(1'b1, 1'b1, 6'd63, 32'hCAFEF00D);
        next_cycle();                                   // cycle 1: write by 0
        #1;
        check_eq("t6_c1_gnt0", {31'd0, rq0_if.gnt}, 32'd1);
        check_eq("t6_c1_din", mem_din, 32'h0BADF00D);
        next_cycle();                                   // cycle 2: 0 done
        drive0(1'b0, 1'b0, 6'd0, 32'd0);
        next_cycle();                                   // cycle 3: write by 1
        #1;
        check_eq("t6_c3_gnt1", {31'd0, rq1_if.gnt}, 32'd1);
        check_eq("t6_c3_addr", {26'd0, mem_addr}, 32'd63);
        check_eq("t6_c3_we", {31'd0, mem_we}, 32'd1);
        next_cycle();                                   // cycle 4: hand back to 0
        drive1(1'b0, 1'b0, 6'd0, 32'd0);
        drive0(1'b1, 1'b0, 6'd63, 32'd0);
        next_cycle();                                   // cycle 5: read 63
        #1;
        check_eq("t6_c5_gnt0", {31'd0, rq0_if.gnt}, 32'd1);
        next_cycle();                                   // cycle 6: response
        drive0(1'b0, 1'b0, 6'd0, 32'd0);
        #1;
        check_eq("t6_c6_rspv0", {31'd0, rq0_if.rsp_valid}, 32'd1);
        check_eq("t6_c6_rspdata", rq0_if.rsp_data, 32'hCAFEF00D);
        check_eq("t6_mem63", mem_q[63], 32'hCAFEF00D);
        next_cycle();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
